// File: rtl/abro_event_arbiter_if.sv
// Shared output port O: a completed channel index offered with valid/ready.
// The arbiter drives the master side; the consumer drives o_ready.
interface abro_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            o_valid;
    logic [ID_W-1:0] o_ch;
    logic            o_ready;

    modport master (output o_valid, output o_ch, input  o_ready);
    modport slave  (input  o_valid, input  o_ch, output o_ready);
endinterface

// File: rtl/abro_event_arbiter.sv
// N_CH independent ABRO channels sharing one output port through a
// round-robin arbiter; stalled half pairs are abandoned after TIMEOUT cycles.
module abro_event_arbiter #(
    parameter int N_CH    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_CH-1:0]      A,
    input  logic [N_CH-1:0]      B,
    input  logic [N_CH-1:0]      R,
    abro_event_arbiter_if.master o_port,
    output logic [N_CH-1:0]      timeout,
    output logic [3*N_CH-1:0]    State
);
    typedef enum logic [2:0] {
        WAIT_AB = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_A  = 3'd2,
        PEND    = 3'd3,
        OFFER   = 3'd4,
        DONE    = 3'd5
    } ch_state_t;

    logic            o_valid_reg;
    logic [ID_W-1:0] o_ch_reg;
    logic [ID_W-1:0] ptr_reg;
    logic            accept;
    logic            port_free;
    logic            load;
    logic            sel_found;
    logic [ID_W-1:0] sel_ch;
    logic [ID_W-1:0] idx;
    logic [N_CH-1:0] pend_vec;

    assign accept    = o_valid_reg & o_port.o_ready;
    assign port_free = ~o_valid_reg | o_port.o_ready;
    assign load      = port_free & sel_found;

    assign o_port.o_valid = o_valid_reg;
    assign o_port.o_ch    = o_ch_reg;

    // First pending channel at or after the pointer, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        idx       = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = ID_W'((int'(ptr_reg) + k) % N_CH);
            if (!sel_found && pend_vec[idx]) begin
                sel_found = 1'b1;
                sel_ch    = idx;
            end
        end
    end

    // A new load may coincide with an acceptance, keeping o_valid high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid_reg <= 1'b0;
            o_ch_reg    <= '0;
            ptr_reg     <= '0;
        end else begin
            if (load) begin
                o_valid_reg <= 1'b1;
                o_ch_reg    <= sel_ch;
            end else if (accept) begin
                o_valid_reg <= 1'b0;
            end
            if (accept) begin
                ptr_reg <= (o_ch_reg == ID_W'(N_CH - 1)) ? '0 : o_ch_reg + ID_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            ch_state_t        state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             to_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_reg <= WAIT_AB;
                    cnt_reg   <= '0;
                    to_reg    <= 1'b0;
                end else begin
                    to_reg <= 1'b0;
                    if (R[gi]) begin
                        state_reg <= WAIT_AB;
                        cnt_reg   <= '0;
                    end else begin
                        case (state_reg)
                            WAIT_AB: begin
                                cnt_reg <= '0;
                                if (A[gi] && B[gi]) state_reg <= PEND;
                                else if (A[gi])     state_reg <= WAIT_B;
                                else if (B[gi])     state_reg <= WAIT_A;
                            end
                            WAIT_B, WAIT_A: begin
                                // The missing event wins over an expiring counter.
                                if ((state_reg == WAIT_B) ? B[gi] : A[gi]) begin
                                    state_reg <= PEND;
                                    cnt_reg   <= '0;
                                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                                    state_reg <= WAIT_AB;
                                    cnt_reg   <= '0;
                                    to_reg    <= 1'b1;
                                end else begin
                                    cnt_reg <= cnt_reg + CNT_W'(1);
                                end
                            end
                            PEND:    if (load && sel_ch == ID_W'(gi))     state_reg <= OFFER;
                            OFFER:   if (accept && o_ch_reg == ID_W'(gi)) state_reg <= DONE;
                            DONE:    ;
                            default: state_reg <= WAIT_AB;
                        endcase
                    end
                end
            end

            assign pend_vec[gi]       = (state_reg == PEND);
            assign State[3*gi +: 3]   = state_reg;
            assign timeout[gi]        = to_reg;
        end
    endgenerate
endmodule

// File: tb/tb_abro_event_arbiter.sv
// Randomized bench for abro_event_arbiter: a flag-based channel model predicts
// states and offers; a monitor compares per cycle and scores accepted offers.
module tb_abro_event_arbiter;
    localparam int N_CH    = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [N_CH-1:0]      a, b, r;
    logic [N_CH-1:0]      timeout;
    logic [3*N_CH-1:0]    state;

    abro_event_arbiter_if #(.ID_W(ID_W)) bus ();

    abro_event_arbiter #(
        .N_CH(N_CH), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .A(a), .B(b), .R(r),
        .o_port(bus), .timeout(timeout), .State(state)
    );

    always #5 clk = ~clk;

    // Reference model: which events a channel has seen, and where its offer stands.
    bit              sa [N_CH];
    bit              sb [N_CH];
    bit              off[N_CH];
    bit              dn [N_CH];
    int              t_first[N_CH];
    bit              m_valid;
    int              m_ch, m_ptr, cyc;
    bit [N_CH-1:0]   m_to;
    int              exp_q[$];
    int              checks = 0;
    int              errors = 0;

    function automatic int code(input int i);
        if (dn[i])              return 5;
        if (off[i])             return 4;
        if (sa[i] && sb[i])     return 3;
        if (sa[i])              return 1;
        if (sb[i])              return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            sa[i] = 0; sb[i] = 0; off[i] = 0; dn[i] = 0; t_first[i] = 0;
        end
        m_valid = 0; m_ch = 0; m_ptr = 0; m_to = '0; cyc = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit accept, free, found, miss;
        int pick, j;
        cyc++;
        accept = m_valid && bus.o_ready;
        free   = !m_valid || bus.o_ready;
        found  = 0;
        pick   = 0;
        for (int k = 0; k < N_CH; k++) begin
            j = (m_ptr + k) % N_CH;
            if (!found && sa[j] && sb[j] && !off[j] && !dn[j]) begin
                found = 1;
                pick  = j;
            end
        end
        m_to = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r[i]) begin
                sa[i] = 0; sb[i] = 0; off[i] = 0; dn[i] = 0;
            end else if (dn[i]) begin
            end else if (off[i]) begin
                if (accept && m_ch == i) begin off[i] = 0; dn[i] = 1; end
            end else if (sa[i] && sb[i]) begin
                if (free && found && pick == i) off[i] = 1;
            end else if (!sa[i] && !sb[i]) begin
                sa[i] = a[i]; sb[i] = b[i]; t_first[i] = cyc;
            end else begin
                miss = sa[i] ? b[i] : a[i];
                if (miss) begin
                    sa[i] = 1; sb[i] = 1;
                end else if (cyc - t_first[i] == TIMEOUT) begin
                    sa[i] = 0; sb[i] = 0; m_to[i] = 1'b1;
                end
            end
        end
        if (accept) m_ptr = (m_ch + 1) % N_CH;
        if (free && found) begin
            m_valid = 1; m_ch = pick; exp_q.push_back(pick);
        end else if (accept) begin
            m_valid = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) model_reset();
        else          model_step();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle comparison plus scoreboard of accepted offers.
    initial forever begin
        @(negedge clk or negedge reset_n);
        if (!reset_n) begin
            #1;
            chk("rst_o_valid", 32'(bus.o_valid), 0);
            chk("rst_o_ch",    32'(bus.o_ch), 0);
            chk("rst_state",   32'(state), 0);
            chk("rst_timeout", 32'(timeout), 0);
        end else begin
            #2;
            for (int i = 0; i < N_CH; i++)
                chk($sformatf("state_ch%0d", i), 32'(state[3*i +: 3]), 32'(code(i)));
            chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
            chk("o_ch",    32'(bus.o_ch), 32'(m_ch));
            chk("timeout", 32'(timeout), 32'(m_to));
            if (bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
                if (exp_q.size() == 0) chk("accept_unexpected", 32'(bus.o_ch), 32'hFFFF_FFFF);
                else                   chk("accept_ch", 32'(bus.o_ch), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic [N_CH-1:0] ia, input logic [N_CH-1:0] ib,
                         input logic [N_CH-1:0] ir, input logic rdy);
        @(negedge clk);
        a = ia; b = ib; r = ir; bus.o_ready = rdy;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) drive('0, '0, '0, rdy);
    endtask

    initial begin
        logic [N_CH-1:0] ia, ib, ir;
        reset_n = 1'b0;
        a = '0; b = '0; r = '0; bus.o_ready = 1'b0;
        repeat (3) @(negedge clk);
        #3 reset_n = 1'b1;

        // Simultaneous A&B on ch0
        drive(4'b0001, 4'b0001, '0, 1'b1);
        idle(4, 1'b1);
        // Ordered A then B on ch1, then B then A after restart
        drive(4'b0010, '0, '0, 1'b1);
        idle(2, 1'b1);
        drive('0, 4'b0010, '0, 1'b1);
        idle(4, 1'b1);
        drive('0, '0, 4'b0010, 1'b1);
        drive('0, 4'b0010, '0, 1'b1);
        idle(2, 1'b1);
        drive(4'b0010, '0, '0, 1'b1);
        idle(4, 1'b1);
        // Round robin with all channels pending, ch0 re-armed mid-sequence
        drive('0, '0, 4'b1111, 1'b1);
        drive(4'b1111, 4'b1111, '0, 1'b1);
        idle(2, 1'b1);
        drive('0, '0, 4'b0001, 1'b1);
        drive(4'b0001, 4'b0001, '0, 1'b1);
        idle(8, 1'b1);
        // Backpressure, restart on the offered channel mid-stall
        drive('0, '0, 4'b1111, 1'b0);
        drive(4'b1000, 4'b1000, '0, 1'b0);
        idle(5, 1'b0);
        drive('0, '0, 4'b1000, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);
        // Timeout on ch2, then the missing event arriving on the last cycle
        drive('0, '0, 4'b1111, 1'b1);
        drive(4'b0100, '0, '0, 1'b1);
        idle(20, 1'b1);
        drive(4'b0100, '0, '0, 1'b1);
        idle(TIMEOUT - 1, 1'b1);
        drive('0, 4'b0100, '0, 1'b1);
        idle(4, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int j = 0; j < N_CH; j++) begin
                ia[j] = ($urandom_range(7) == 0);
                ib[j] = ($urandom_range(7) == 0);
                ir[j] = ($urandom_range(23) == 0);
            end
            drive(ia, ib, ir, ($urandom_range(3) != 0));
        end

        // Asynchronous reset while an offer is stalled
        drive('0, '0, 4'b1111, 1'b0);
        drive(4'b0001, 4'b0001, '0, 1'b0);
        idle(3, 1'b0);
        @(negedge clk);
        #3 reset_n = 1'b0;
        @(negedge clk);
        #3 reset_n = 1'b1;
        idle(4, 1'b1);
        @(negedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
